flow_control_fifo: RTL



---
 rtl/flow_control_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/flow_control_fifo.sv
// Byte FIFO from usb_uart to command_handler, plus the keyboard-to-host path.
// When FLOW_EN is set, XOFF/XON bytes are injected into the host path based on
// the FIFO fill level, so the host pauses before the FIFO overflows.
module flow_control_fifo #(
    parameter int DEPTH_BITS = 6,
    parameter int XOFF_LEVEL = 48,
    parameter int XON_LEVEL  = 16,
    parameter bit FLOW_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic                kbd_ready,
    output logic [7:0]          host_data,
    output logic                host_valid,
    input  logic                host_ready,
    output logic [DEPTH_BITS:0] count,
    output logic                paused
);

    localparam int CW = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS:0]   CAP      = CW'(2 ** DEPTH_BITS);
    localparam logic [DEPTH_BITS:0]   XOFF_CNT = CW'(XOFF_LEVEL);
    localparam logic [DEPTH_BITS:0]   XON_CNT  = CW'(XON_LEVEL);
    localparam logic [DEPTH_BITS:0]   CNT_ONE  = CW'(1);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
    localparam logic [7:0]            XON_BYTE  = 8'h11;
    localparam logic [7:0]            XOFF_BYTE = 8'h13;

    typedef enum logic {
        HOST_EMPTY,
        HOST_LOADED
    } host_state_e;

    // FIFO state: circular buffer behind a registered output stage
    logic [7:0]            mem_q [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [7:0]            out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  push, pop, mem_empty, mem_wr;

    // Host output register state
    host_state_e           host_state_q, host_state_d;
    logic [7:0]            host_data_q, host_data_d;
    logic                  paused_q, paused_d;
    logic                  ctrl_req;
    logic [7:0]            ctrl_byte;

    assign in_ready   = (count_q != CAP);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign count      = count_q;
    assign host_data  = host_data_q;
    assign host_valid = (host_state_q == HOST_LOADED);
    assign paused     = paused_q;

    // FIFO next state: refill the output stage from memory, or bypass an empty FIFO
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        mem_wr      = 1'b0;

        push      = in_valid && in_ready;
        pop       = out_valid_q && out_ready;
        mem_empty = (count_q == CW'(out_valid_q));

        if (!out_valid_q || pop) begin
            if (!mem_empty) begin
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                mem_wr      = push;
            end else if (push) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            mem_wr = push;
        end

        if (mem_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Host register next state: control bytes win over keyboard bytes when empty
    always_comb begin
        host_state_d = host_state_q;
        host_data_d  = host_data_q;
        paused_d     = paused_q;
        kbd_ready    = 1'b0;

        // Re-evaluated every cycle so a level that falls back never sends a stale XOFF.
        ctrl_req  = FLOW_EN && ((!paused_q && count_q >= XOFF_CNT) ||
                                ( paused_q && count_q <= XON_CNT));
        ctrl_byte = paused_q ? XON_BYTE : XOFF_BYTE;

        unique case (host_state_q)
            HOST_EMPTY: begin
                if (ctrl_req) begin
                    host_data_d  = ctrl_byte;
                    paused_d     = !paused_q;
                    host_state_d = HOST_LOADED;
                end else begin
                    kbd_ready = 1'b1;
                    if (kbd_valid) begin
                        host_data_d  = kbd_data;
                        host_state_d = HOST_LOADED;
                    end
                end
            end
            HOST_LOADED: begin
                if (host_ready) begin
                    host_state_d = HOST_EMPTY;
                end
            end
            default: host_state_d = HOST_EMPTY;
        endcase
    end

    // Control and data registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            host_state_q <= HOST_EMPTY;
            host_data_q  <= '0;
            paused_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            host_state_q <= host_state_d;
            host_data_q  <= host_data_d;
            paused_q     <= paused_d;
        end
    end

    // Buffer storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and
        // count define which entries are meaningful, so stale bytes are never read.
        if (mem_wr) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
